// File: rtl/dram_arb.sv
// Two-port arbiter sharing the single-port data RAM between the core (C) and an
// auxiliary bus master (A). Core has priority; a bounded wait counter guarantees A progress.
module dram_arb #(
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned ADDR_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_req,
  input  logic        c_wr,
  input  logic [31:0] c_addr,
  input  logic [3:0]  c_mask,
  input  logic [31:0] c_din,
  output logic        c_ack,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  input  logic        a_req,
  input  logic        a_wr,
  input  logic [31:0] a_addr,
  input  logic [3:0]  a_mask,
  input  logic [31:0] a_din,
  output logic        a_ack,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  output logic        ram_cs,
  output logic        ram_wr,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_mask,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_C,
    OWN_A
  } owner_e;

  localparam logic [31:0] ADDR_MASK  = (ADDR_BITS >= 32) ? 32'hFFFF_FFFF
                                                         : ((32'd1 << ADDR_BITS) - 32'd1);
  localparam logic [3:0]  MAX_WAIT_C = 4'(MAX_WAIT);

  owner_e     rd_owner_q, rd_owner_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       grant_c, grant_a;

  // A wins only when C is absent or A has waited its full budget.
  always_comb begin
    grant_c = 1'b0;
    grant_a = 1'b0;
    if (rst_n) begin
      if (a_req && (!c_req || wait_cnt_q == MAX_WAIT_C)) begin
        grant_a = 1'b1;
      end else if (c_req) begin
        grant_c = 1'b1;
      end
    end
  end

  assign c_ack = grant_c;
  assign a_ack = grant_a;

  always_comb begin
    ram_cs   = grant_c | grant_a;
    ram_wr   = 1'b0;
    ram_addr = '0;
    ram_mask = '0;
    ram_din  = '0;
    if (grant_a) begin
      ram_wr   = a_wr;
      ram_addr = a_addr & ADDR_MASK;
      ram_mask = a_mask;
      ram_din  = a_din;
    end else if (grant_c) begin
      ram_wr   = c_wr;
      ram_addr = c_addr & ADDR_MASK;
      ram_mask = c_mask;
      ram_din  = c_din;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!a_req || grant_a) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    rd_owner_d = OWN_NONE;
    if (grant_a && !a_wr) begin
      rd_owner_d = OWN_A;
    end else if (grant_c && !c_wr) begin
      rd_owner_d = OWN_C;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      rd_owner_q <= OWN_NONE;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // RAM data is registered inside the RAM, so the owner tag lines up with ram_dout.
  assign c_rvalid = (rd_owner_q == OWN_C);
  assign a_rvalid = (rd_owner_q == OWN_A);
  assign c_rdata  = c_rvalid ? ram_dout : '0;
  assign a_rdata  = a_rvalid ? ram_dout : '0;

endmodule

// File: tb/tb_dram_arb.sv
// Bench for dram_arb: behavioural RAM, shadow-memory reference model, directed and random scenarios.
module tb_dram_arb;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        c_req = 1'b0, c_wr = 1'b0;
  logic [31:0] c_addr = '0, c_din = '0;
  logic [3:0]  c_mask = '0;
  logic        a_req = 1'b0, a_wr = 1'b0;
  logic [31:0] a_addr = '0, a_din = '0;
  logic [3:0]  a_mask = '0;
  logic        c_ack, c_rvalid, a_ack, a_rvalid;
  logic [31:0] c_rdata, a_rdata;
  logic        ram_cs, ram_wr;
  logic [31:0] ram_addr, ram_din;
  logic [3:0]  ram_mask;
  logic [31:0] ram_dout;

  dram_arb #(.MAX_WAIT(MAX_WAIT), .ADDR_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_mask(c_mask), .c_din(c_din),
    .c_ack(c_ack), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_mask(a_mask), .a_din(a_din),
    .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .ram_cs(ram_cs), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_mask(ram_mask),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // 32 KB single-port RAM with registered read data
  logic [31:0] mem    [0:8191];
  logic [31:0] shadow [0:8191];

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_wr) begin
        for (int b = 0; b < 4; b++)
          if (ram_mask[b]) mem[ram_addr[14:2]][8*b +: 8] <= ram_din[8*b +: 8];
      end else begin
        ram_dout <= mem[ram_addr[14:2]];
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int m_wait = 0;   // consecutive cycles A has been refused
  int m_owner = 0;  // 0 none, 1 core, 2 aux: who gets read data this cycle
  logic [31:0] m_rdata = '0;

  // Who should be granted right now, from the priority/fairness rules.
  function automatic int exp_grant();
    if (!rst_n) return 0;
    if (c_req && a_req) return (m_wait == MAX_WAIT) ? 2 : 1;
    if (c_req) return 1;
    if (a_req) return 2;
    return 0;
  endfunction

  function automatic void shadow_write(input logic [31:0] addr, input logic [3:0] mask,
                                       input logic [31:0] din);
    for (int b = 0; b < 4; b++)
      if (mask[b]) shadow[addr[14:2]][8*b +: 8] = din[8*b +: 8];
  endfunction

  task automatic model_edge();
    int g;
    g = exp_grant();
    if (!rst_n) begin
      m_wait = 0;
      m_owner = 0;
      return;
    end
    if (!a_req || g == 2) m_wait = 0;
    else if (m_wait < MAX_WAIT) m_wait++;
    m_owner = 0;
    if (g == 1) begin
      if (!c_wr) begin m_owner = 1; m_rdata = shadow[c_addr[14:2]]; end
      else shadow_write(c_addr, c_mask, c_din);
    end else if (g == 2) begin
      if (!a_wr) begin m_owner = 2; m_rdata = shadow[a_addr[14:2]]; end
      else shadow_write(a_addr, a_mask, a_din);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    c_req = 1'b0;
    a_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; c_req = 1'b1; a_req = 1'b1; c_wr = 1'b0; a_wr = 1'b0;
    c_addr = 32'h0; a_addr = 32'h4;
    #3;
    n_cmp++;
    if ({c_ack, a_ack, ram_cs, ram_wr} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_acks: got %b want 0000", {c_ack, a_ack, ram_cs, ram_wr});
    end
    n_cmp++;
    if ({c_rvalid, a_rvalid} !== 2'b00) begin
      n_bad++; $display("FAIL reset_rvalid: got %b want 00", {c_rvalid, a_rvalid});
    end
    tick();
    rst_n = 1'b1;
    #3;
    n_cmp++;
    if ({c_ack, a_ack, ram_cs} !== 3'b101) begin
      n_bad++; $display("FAIL reset_release_grant: got %b want 101", {c_ack, a_ack, ram_cs});
    end
    tick();
    idle();
  endtask

  task automatic test_core_read();
    mem[4] = 32'hDEADBEEF; shadow[4] = 32'hDEADBEEF;
    c_req = 1'b1; c_wr = 1'b0; c_addr = 32'h0000_0010;
    #3;
    n_cmp++;
    if ({c_ack, a_ack, ram_cs, ram_wr} !== 4'b1010) begin
      n_bad++; $display("FAIL core_read_grant: got %b want 1010", {c_ack, a_ack, ram_cs, ram_wr});
    end
    tick();
    idle();
    #3;
    n_cmp++;
    if ({c_rvalid, a_rvalid} !== 2'b10 || c_rdata !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL core_read_data: got v=%b d=%h want v=10 d=deadbeef",
                        {c_rvalid, a_rvalid}, c_rdata);
    end
    tick();
  endtask

  task automatic test_masked_write();
    mem[8] = 32'hAABBCCDD; shadow[8] = 32'hAABBCCDD;
    a_req = 1'b1; a_wr = 1'b1; a_addr = 32'h0000_0020; a_mask = 4'b0101; a_din = 32'h11223344;
    #3;
    n_cmp++;
    if ({a_ack, c_ack, ram_cs, ram_wr, ram_mask} !== 8'b1011_0101 || ram_din !== 32'h11223344) begin
      n_bad++; $display("FAIL masked_write_fwd: got ack/cs/wr/mask=%b din=%h want 10110101 11223344",
                        {a_ack, c_ack, ram_cs, ram_wr, ram_mask}, ram_din);
    end
    tick();
    a_req = 1'b0;
    c_req = 1'b1; c_wr = 1'b0; c_addr = 32'h0000_0020;
    #3;
    tick();
    idle();
    #3;
    n_cmp++;
    if (c_rvalid !== 1'b1 || c_rdata !== 32'hAA22CC44) begin
      n_bad++; $display("FAIL masked_write_readback: got v=%b d=%h want 1 aa22cc44", c_rvalid, c_rdata);
    end
    tick();
  endtask

  task automatic test_fairness();
    int a_cnt;
    a_cnt = 0;
    c_req = 1'b1; c_wr = 1'b0; c_addr = 32'h100;
    a_req = 1'b1; a_wr = 1'b0; a_addr = 32'h200;
    for (int i = 0; i < 20; i++) begin
      logic exp_a;
      exp_a = (i % 5 == 4);
      #3;
      n_cmp++;
      if ({c_ack, a_ack} !== {~exp_a, exp_a}) begin
        n_bad++; $display("FAIL fairness_cycle%0d: got c/a=%b want %b", i, {c_ack, a_ack}, {~exp_a, exp_a});
      end
      if (a_ack === 1'b1) a_cnt++;
      tick();
    end
    idle();
    n_cmp++;
    if (a_cnt !== 4) begin
      n_bad++; $display("FAIL fairness_a_count: got %0d want 4", a_cnt);
    end
    #3;
    tick();
  endtask

  task automatic test_pipelined();
    mem[0] = 32'h01234567; shadow[0] = 32'h01234567;
    mem[1] = 32'h89ABCDEF; shadow[1] = 32'h89ABCDEF;
    c_req = 1'b1; c_wr = 1'b0; c_addr = 32'h0;
    #3;
    tick();
    c_req = 1'b0;
    a_req = 1'b1; a_wr = 1'b0; a_addr = 32'h4;
    #3;
    n_cmp++;
    if ({c_rvalid, a_rvalid, a_ack} !== 3'b101 || c_rdata !== 32'h01234567) begin
      n_bad++; $display("FAIL pipe_c_rvalid: got v/v/ack=%b d=%h want 101 01234567",
                        {c_rvalid, a_rvalid, a_ack}, c_rdata);
    end
    tick();
    a_req = 1'b0;
    c_req = 1'b1; c_wr = 1'b1; c_addr = 32'h8; c_mask = 4'hF; c_din = 32'h5A5A5A5A;
    #3;
    n_cmp++;
    if ({c_rvalid, a_rvalid, c_ack} !== 3'b011 || a_rdata !== 32'h89ABCDEF) begin
      n_bad++; $display("FAIL pipe_a_rvalid: got v/v/ack=%b d=%h want 011 89abcdef",
                        {c_rvalid, a_rvalid, c_ack}, a_rdata);
    end
    tick();
    idle();
    #3;
    n_cmp++;
    if ({c_rvalid, a_rvalid} !== 2'b00) begin
      n_bad++; $display("FAIL pipe_write_no_rvalid: got %b want 00", {c_rvalid, a_rvalid});
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    c_req = 1'b1; c_wr = 1'b0; c_addr = 32'h10;
    #3;
    tick();
    idle();
    n_cmp++;
    if (c_rvalid !== 1'b1) begin
      n_bad++; $display("FAIL midrst_pre_rvalid: got %b want 1", c_rvalid);
    end
    rst_n = 1'b0;
    #1;
    m_owner = 0; m_wait = 0;
    n_cmp++;
    if ({c_rvalid, a_rvalid} !== 2'b00) begin
      n_bad++; $display("FAIL midrst_async_clear: got %b want 00", {c_rvalid, a_rvalid});
    end
    #2;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3;
      n_cmp++;
      if ({c_rvalid, a_rvalid} !== 2'b00) begin
        n_bad++; $display("FAIL midrst_after_release%0d: got %b want 00", i, {c_rvalid, a_rvalid});
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      int g;
      logic [31:0] e_addr, e_din;
      logic [3:0]  e_mask;
      logic        e_wr;
      if (!c_req && $urandom_range(0, 9) < 6) begin
        c_req = 1'b1; c_wr = $urandom_range(0, 1) == 1; c_addr = $urandom;
        c_mask = 4'($urandom); c_din = $urandom;
      end else if (c_req && $urandom_range(0, 15) == 0) c_req = 1'b0;
      if (!a_req && $urandom_range(0, 9) < 6) begin
        a_req = 1'b1; a_wr = $urandom_range(0, 1) == 1; a_addr = $urandom;
        a_mask = 4'($urandom); a_din = $urandom;
      end else if (a_req && $urandom_range(0, 15) == 0) a_req = 1'b0;
      #3;
      g = exp_grant();
      n_cmp++;
      if ({c_ack, a_ack, ram_cs} !== {g == 1, g == 2, g != 0}) begin
        n_bad++; $display("FAIL rand_grant@%0d: got c/a/cs=%b want %b wait=%0d", cyc,
                          {c_ack, a_ack, ram_cs}, {g == 1, g == 2, g != 0}, m_wait);
      end
      if (g != 0) begin
        e_wr   = (g == 1) ? c_wr : a_wr;
        e_addr = ((g == 1) ? c_addr : a_addr) & 32'h0000_FFFF;
        e_mask = (g == 1) ? c_mask : a_mask;
        e_din  = (g == 1) ? c_din : a_din;
        n_cmp++;
        if ({ram_wr, ram_addr, ram_mask, ram_din} !== {e_wr, e_addr, e_mask, e_din}) begin
          n_bad++; $display("FAIL rand_ram_fwd@%0d: got wr=%b a=%h m=%b d=%h want wr=%b a=%h m=%b d=%h",
                            cyc, ram_wr, ram_addr, ram_mask, ram_din, e_wr, e_addr, e_mask, e_din);
        end
      end
      n_cmp++;
      if ({c_rvalid, a_rvalid} !== {m_owner == 1, m_owner == 2} ||
          c_rdata !== ((m_owner == 1) ? m_rdata : 32'h0) ||
          a_rdata !== ((m_owner == 2) ? m_rdata : 32'h0)) begin
        n_bad++; $display("FAIL rand_read_return@%0d: got v=%b cd=%h ad=%h want owner=%0d d=%h",
                          cyc, {c_rvalid, a_rvalid}, c_rdata, a_rdata, m_owner, m_rdata);
      end
      tick();
      if (g == 1) c_req = 1'b0;
      if (g == 2) a_req = 1'b0;
    end
    idle();
    #3;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin
      mem[i] = $urandom;
      shadow[i] = mem[i];
    end
    @(posedge clk);
    #1;
    test_reset();
    test_core_read();
    test_masked_write();
    test_fairness();
    test_pipelined();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
